// File: rtl/shader_l2_arbiter.sv
// Round-robin arbiter sharing one L2 request port between shader clusters 0 and 1.
// Latency: request sampled in IDLE -> grant + L2 command next cycle -> rsp_valid_o one cycle after l2_ready_i.
// Backpressure: one transaction in flight; other requesters hold req_i until granted; enable_i=0 blocks new grants.
// Optional macro SHADER_L2_ARB_TIMEOUT_EN adds a BUSY watchdog that ends stuck transactions with rsp_err_o=1.
module shader_l2_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 256,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                enable_i,
    input  logic [1:0]          req_i,
    input  logic [1:0]          req_we_i,
    input  logic [2*ADDR_W-1:0] req_addr_i,
    input  logic [2*DATA_W-1:0] req_wdata_i,
    output logic [1:0]          gnt_o,
    output logic [1:0]          rsp_valid_o,
    output logic [DATA_W-1:0]   rsp_rdata_o,
    output logic                rsp_err_o,
    output logic [ADDR_W-1:0]   l2_addr_o,
    output logic [DATA_W-1:0]   l2_wdata_o,
    output logic                l2_read_o,
    output logic                l2_write_o,
    input  logic                l2_ready_i,
    input  logic [DATA_W-1:0]   l2_rdata_i,
    output logic                busy_o,
    output logic [31:0]         grant_cnt0_o,
    output logic [31:0]         grant_cnt1_o,
    output logic [31:0]         conflict_cnt_o
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic                last_grant_q;
    logic                owner_q;
    logic                winner;
    logic                arb_go;
    logic                both_req;
    logic                xfer_done;
    logic                timeout_hit;
    logic                win_we;
    logic [ADDR_W-1:0]   win_addr;
    logic [DATA_W-1:0]   win_wdata;

    // Arbitration: with both requesting, the port that was not served last wins
    always_comb begin
        both_req  = &req_i;
        winner    = both_req ? ~last_grant_q : req_i[1];
        arb_go    = (state_q == ST_IDLE) && enable_i && (|req_i);
        win_we    = req_we_i[winner];
        win_addr  = winner ? req_addr_i[2*ADDR_W-1:ADDR_W] : req_addr_i[ADDR_W-1:0];
        win_wdata = winner ? req_wdata_i[2*DATA_W-1:DATA_W] : req_wdata_i[DATA_W-1:0];
        xfer_done = (state_q == ST_BUSY) && (l2_ready_i || timeout_hit);
    end

`ifdef SHADER_L2_ARB_TIMEOUT_EN
    logic [31:0] wd_cnt_q;

    // A real L2 completion always takes precedence over the watchdog firing
    assign timeout_hit = !l2_ready_i && (wd_cnt_q == 32'(TIMEOUT_CYCLES - 1));

    // Watchdog restarts on BUSY entry and counts BUSY cycles left unanswered by L2
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wd_cnt_q <= '0;
        end else if (arb_go) begin
            wd_cnt_q <= '0;
        end else if ((state_q == ST_BUSY) && !l2_ready_i) begin
            wd_cnt_q <= wd_cnt_q + 32'd1;
        end
    end

    // Error flag travels with the response of a timed-out transaction
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rsp_err_o <= 1'b0;
        end else if (xfer_done) begin
            rsp_err_o <= timeout_hit;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign rsp_err_o   = 1'b0;
`endif

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: IDLE -> BUSY on a grant, BUSY -> RESP on completion, RESP -> IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (arb_go)    state_d = ST_BUSY;
            ST_BUSY: if (xfer_done) state_d = ST_RESP;
            ST_RESP:                state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    // Registered grant, L2 command, response and counters
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            gnt_o          <= '0;
            rsp_valid_o    <= '0;
            rsp_rdata_o    <= '0;
            l2_addr_o      <= '0;
            l2_wdata_o     <= '0;
            l2_read_o      <= 1'b0;
            l2_write_o     <= 1'b0;
            grant_cnt0_o   <= '0;
            grant_cnt1_o   <= '0;
            conflict_cnt_o <= '0;
            owner_q        <= 1'b0;
            last_grant_q   <= 1'b1;
        end else begin
            gnt_o       <= '0;
            rsp_valid_o <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (arb_go) begin
                        owner_q    <= winner;
                        gnt_o      <= winner ? 2'b10 : 2'b01;
                        l2_addr_o  <= win_addr;
                        l2_wdata_o <= win_wdata;
                        l2_write_o <= win_we;
                        l2_read_o  <= ~win_we;
                        if (winner) grant_cnt1_o <= grant_cnt1_o + 32'd1;
                        else        grant_cnt0_o <= grant_cnt0_o + 32'd1;
                        if (both_req) conflict_cnt_o <= conflict_cnt_o + 32'd1;
                    end
                end
                ST_BUSY: begin
                    if (xfer_done) begin
                        l2_read_o   <= 1'b0;
                        l2_write_o  <= 1'b0;
                        rsp_valid_o <= owner_q ? 2'b10 : 2'b01;
                        rsp_rdata_o <= (timeout_hit || l2_write_o) ? '0 : l2_rdata_i;
                    end
                end
                ST_RESP: begin
                    last_grant_q <= owner_q;
                end
                default: ;
            endcase
        end
    end

    assign busy_o = (state_q != ST_IDLE);

endmodule

// File: tb/tb_shader_l2_arbiter.sv
// Bench for shader_l2_arbiter: directed scenarios with a transaction-level reference model.
// The model predicts grants, commands, responses and counters; a negedge process compares every cycle.
// Define SHADER_L2_ARB_TIMEOUT_EN to also exercise the watchdog (TIMEOUT_CYCLES=16).
module tb_shader_l2_arbiter;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 256;
    localparam int TO_CYC = 16;

    logic                clk;
    logic                rst;
    logic                enable;
    logic [1:0]          req;
    logic [1:0]          req_we;
    logic [2*ADDR_W-1:0] req_addr;
    logic [2*DATA_W-1:0] req_wdata;
    logic [1:0]          gnt_o;
    logic [1:0]          rsp_valid_o;
    logic [DATA_W-1:0]   rsp_rdata_o;
    logic                rsp_err_o;
    logic [ADDR_W-1:0]   l2_addr_o;
    logic [DATA_W-1:0]   l2_wdata_o;
    logic                l2_read_o;
    logic                l2_write_o;
    logic                l2_ready;
    logic [DATA_W-1:0]   l2_rdata;
    logic                busy_o;
    logic [31:0]         grant_cnt0_o;
    logic [31:0]         grant_cnt1_o;
    logic [31:0]         conflict_cnt_o;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int rsp_delay = 0;

    shader_l2_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TO_CYC)) dut (
        .clk_i(clk), .rst_i(rst), .enable_i(enable),
        .req_i(req), .req_we_i(req_we), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .gnt_o(gnt_o), .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .l2_addr_o(l2_addr_o), .l2_wdata_o(l2_wdata_o), .l2_read_o(l2_read_o), .l2_write_o(l2_write_o),
        .l2_ready_i(l2_ready), .l2_rdata_i(l2_rdata), .busy_o(busy_o),
        .grant_cnt0_o(grant_cnt0_o), .grant_cnt1_o(grant_cnt1_o), .conflict_cnt_o(conflict_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // L2 responder: answers rsp_delay cycles after a command appears, with tagged read data
    initial begin
        int          wait_cnt;
        logic [31:0] salt;
        wait_cnt = 0;
        salt     = 32'd0;
        l2_ready = 1'b0;
        l2_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            if ((l2_read_o || l2_write_o) && !rst) begin
                if (wait_cnt >= rsp_delay) begin
                    l2_ready = 1'b1;
                    l2_rdata = {8{32'hD000_0000 + salt}};
                    salt     = salt + 32'd1;
                    wait_cnt = 0;
                end else begin
                    l2_ready = 1'b0;
                    wait_cnt++;
                end
            end else begin
                l2_ready = 1'b0;
                wait_cnt = 0;
            end
        end
    end

    // Reference model: one open transaction, a one-cycle response slot, round-robin memory
    logic              m_open, m_resp, m_owner, m_last, m_we, to_now;
    int                m_wait;
    logic [1:0]        e_gnt, e_rsp;
    logic              e_err, e_read, e_write;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_rdata, e_wdata;
    logic [31:0]       e_cnt0, e_cnt1, e_conf;

    task automatic model_close(input logic err, input logic [DATA_W-1:0] rd);
        m_open  = 1'b0;
        m_resp  = 1'b1;
        e_rsp   = m_owner ? 2'b10 : 2'b01;
        e_err   = err;
        e_rdata = rd;
        e_read  = 1'b0;
        e_write = 1'b0;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_open = 0; m_resp = 0; m_owner = 0; m_last = 1; m_we = 0; m_wait = 0;
            e_gnt = '0; e_rsp = '0; e_err = 0; e_read = 0; e_write = 0;
            e_addr = '0; e_rdata = '0; e_wdata = '0;
            e_cnt0 = '0; e_cnt1 = '0; e_conf = '0;
        end else begin
            e_gnt = 2'b00;
            e_rsp = 2'b00;
            if (m_resp) begin
                m_resp = 1'b0;
                m_last = m_owner;
            end else if (m_open) begin
                to_now = 1'b0;
`ifdef SHADER_L2_ARB_TIMEOUT_EN
                to_now = (m_wait == TO_CYC - 1);
`endif
                if (l2_ready)    model_close(1'b0, m_we ? {DATA_W{1'b0}} : l2_rdata);
                else if (to_now) model_close(1'b1, {DATA_W{1'b0}});
                else             m_wait++;
            end else if (enable && (req != 2'b00)) begin
                m_owner = (req == 2'b11) ? ~m_last : req[1];
                if (req == 2'b11) e_conf = e_conf + 32'd1;
                if (m_owner) e_cnt1 = e_cnt1 + 32'd1;
                else         e_cnt0 = e_cnt0 + 32'd1;
                e_gnt   = m_owner ? 2'b10 : 2'b01;
                m_we    = req_we[m_owner];
                e_addr  = m_owner ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
                e_wdata = m_owner ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
                e_read  = ~m_we;
                e_write = m_we;
                m_open  = 1'b1;
                m_wait  = 0;
            end
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (!rst) begin
            check("gnt", gnt_o, e_gnt);
            check("rsp_valid", rsp_valid_o, e_rsp);
            check("l2_read", l2_read_o, e_read);
            check("l2_write", l2_write_o, e_write);
            check("busy", busy_o, m_open || m_resp);
            check("grant_cnt0", grant_cnt0_o, e_cnt0);
            check("grant_cnt1", grant_cnt1_o, e_cnt1);
            check("conflict_cnt", conflict_cnt_o, e_conf);
            if (e_read || e_write) begin
                check("l2_addr", l2_addr_o, e_addr);
                check("l2_wdata", l2_wdata_o, e_wdata);
            end
            if (e_rsp != 2'b00) begin
                check("rsp_rdata", rsp_rdata_o, e_rdata);
                check("rsp_err", rsp_err_o, e_err);
            end
        end
    end

    task automatic wait_gnt(input logic [1:0] want, input string name);
        int n = 0;
        while (gnt_o == 2'b00 && n < 12) begin
            @(negedge clk);
            n++;
        end
        check(name, gnt_o, want);
    endtask

    task automatic wait_rsp(input logic [1:0] want, input string name, input int limit);
        int n = 0;
        while (rsp_valid_o == 2'b00 && n < limit) begin
            @(negedge clk);
            n++;
        end
        check(name, rsp_valid_o, want);
    endtask

    task automatic pulse_reset();
        @(negedge clk); #1 rst = 1'b1;
        @(negedge clk); #1 rst = 1'b0;
    endtask

    initial begin
        int                t0, n, stable, cnt;
        logic [DATA_W-1:0] exp_rd;
        rst = 1'b1; enable = 1'b0; req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        repeat (2) @(negedge clk);
        check("rst_gnt", gnt_o, 2'b00);
        check("rst_busy", busy_o, 1'b0);
        check("rst_cmd", {l2_read_o, l2_write_o}, 2'b00);
        check("rst_cnt0", grant_cnt0_o, 32'd0);
        #1 rst = 1'b0;
        enable = 1'b1;
        @(negedge clk);

        // 1: lone port-0 read, L2 answers in the grant cycle
        rsp_delay = 0;
        req_addr[ADDR_W-1:0] = 32'h0000_0100;
        req_we = 2'b00;
        req = 2'b01;
        t0 = cyc;
        wait_gnt(2'b01, "t1_gnt");
        check("t1_gnt_latency", 32'(cyc - t0), 32'd1);
        req = 2'b00;
        wait_rsp(2'b01, "t1_rsp", 10);
        check("t1_rsp_latency", 32'(cyc - t0), 32'd2);
        exp_rd = {8{32'hD000_0000}};
        check("t1_rdata", rsp_rdata_o, exp_rd);
        check("t1_grant_cnt0", grant_cnt0_o, 32'd1);

        // 2: both ports request continuously for six transactions
        pulse_reset();
        req_addr  = {32'h0000_0300, 32'h0000_0200};
        req_wdata = {{8{32'h1111_0001}}, {8{32'h2222_0002}}};
        req_we    = 2'b10;
        req       = 2'b11;
        for (int i = 0; i < 6; i++) begin
            wait_gnt((i % 2 == 1) ? 2'b10 : 2'b01, "t2_order");
            if (i == 5) req = 2'b00;
            @(negedge clk);
        end
        wait_rsp(2'b10, "t2_last_rsp", 10);
        check("t2_conflict", conflict_cnt_o, 32'd6);
        check("t2_cnt0", grant_cnt0_o, 32'd3);
        check("t2_cnt1", grant_cnt1_o, 32'd3);

        // 3: port-1 write with L2 answering after five wait cycles
        @(negedge clk);
        rsp_delay = 5;
        req_addr[2*ADDR_W-1:ADDR_W]  = 32'h4000_0040;
        req_wdata[2*DATA_W-1:DATA_W] = {8{32'hCAFE_0003}};
        req_we = 2'b10;
        req = 2'b10;
        wait_gnt(2'b10, "t3_gnt");
        req = 2'b00;
        n = 0;
        stable = 0;
        while (l2_write_o === 1'b1 && n < 20) begin
            if (l2_addr_o === 32'h4000_0040 && l2_wdata_o === {8{32'hCAFE_0003}}) stable++;
            n++;
            @(negedge clk);
        end
        check("t3_cmd_cycles", 32'(n), 32'd6);
        check("t3_stable_cycles", 32'(stable), 32'd6);
        check("t3_rsp", rsp_valid_o, 2'b10);
        check("t3_rdata", rsp_rdata_o, {DATA_W{1'b0}});

        // 4: enable gating, then enable dropped while a transaction is in flight
        rsp_delay = 0;
        req_we = 2'b00;
        enable = 1'b0;
        req = 2'b11;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (gnt_o != 2'b00) cnt++;
        end
        check("t4_blocked_gnts", 32'(cnt), 32'd0);
        enable = 1'b1;
        wait_gnt(2'b01, "t4_first_gnt");
        enable = 1'b0;
        wait_rsp(2'b01, "t4_inflight_rsp", 10);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (gnt_o != 2'b00) cnt++;
        end
        check("t4_held_idle", 32'(cnt), 32'd0);
        check("t4_idle_busy", busy_o, 1'b0);
        enable = 1'b1;
        wait_gnt(2'b10, "t4_rr_gnt");
        req = 2'b00;
        wait_rsp(2'b10, "t4_rr_rsp", 10);

        // 5: reset two cycles into BUSY
        rsp_delay = 100000;
        req_we = 2'b10;
        req = 2'b10;
        wait_gnt(2'b10, "t5_gnt");
        req = 2'b00;
        @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("t5_rst_gnt", gnt_o, 2'b00);
        check("t5_rst_rsp", rsp_valid_o, 2'b00);
        check("t5_rst_cmd", {l2_read_o, l2_write_o}, 2'b00);
        check("t5_rst_busy", busy_o, 1'b0);
        check("t5_rst_addr", l2_addr_o, 32'd0);
        check("t5_rst_cnt1", grant_cnt1_o, 32'd0);
        #1 rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rsp_valid_o != 2'b00) cnt++;
        end
        check("t5_no_rsp", 32'(cnt), 32'd0);
        rsp_delay = 0;
        req_we = 2'b00;
        req = 2'b11;
        wait_gnt(2'b01, "t5_next_gnt");
        req = 2'b00;
        wait_rsp(2'b01, "t5_next_rsp", 10);

`ifdef SHADER_L2_ARB_TIMEOUT_EN
        // 6: L2 never answers; the watchdog ends the transaction with an error
        @(negedge clk);
        rsp_delay = 100000;
        req = 2'b01;
        wait_gnt(2'b01, "t6_gnt");
        req = 2'b00;
        n = 0;
        while (l2_read_o === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        check("t6_busy_cycles", 32'(n), 32'd16);
        check("t6_rsp", rsp_valid_o, 2'b01);
        check("t6_err", rsp_err_o, 1'b1);
        check("t6_rdata", rsp_rdata_o, {DATA_W{1'b0}});
        rsp_delay = 0;
        req = 2'b10;
        wait_gnt(2'b10, "t6_next_gnt");
        req = 2'b00;
        wait_rsp(2'b10, "t6_next_rsp", 10);
        check("t6_next_err", rsp_err_o, 1'b0);
`endif

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
